// File: rtl/ccm_pkg.sv
// ccm_pkg: shared widths, stream count and request FSM
// encoding for the CCM counter keystream consumer.
package ccm_pkg;

    localparam int WIDTH_KEY = 128;
    localparam int N_STREAMS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HOLD = 2'd2
    } req_state_e;

endpackage

// File: rtl/ccm_ks_fifo.sv
// ccm_ks_fifo: single-clock keystream FIFO with exposed
// occupancy; the head is only visible once a block is stored.
module ccm_ks_fifo
    import ccm_pkg::*;
#(
    parameter int  W     = WIDTH_KEY,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int FW    = AW + 1
) (
    input  logic          clk,
    input  logic          kill,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [FW-1:0] fill_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [FW-1:0] fill_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && (fill_q != FW'(DEPTH));
    assign do_pop  = pop_i && (fill_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign fill_o  = fill_q;

    always_ff @(posedge clk) begin
        if (kill) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ccm_ctr_xor.sv
// ccm_ctr_xor: requests encrypted counters per stream, buffers
// them, and XORs each block with one payload word.
module ccm_ctr_xor #(
    parameter int WIDTH_KEY = ccm_pkg::WIDTH_KEY,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 kill,
    input  logic                 run,
    output logic                 ctr_ready,
    output logic                 ctr_stream_idx,
    input  logic                 ctr_en,
    input  logic                 ctr_ret_idx,
    input  logic [WIDTH_KEY-1:0] ctr_data,
    input  logic                 in_valid,
    input  logic                 in_stream_idx,
    input  logic [WIDTH_KEY-1:0] in_data,
    output logic                 in_accept,
    output logic                 out_valid,
    output logic                 out_stream_idx,
    output logic [WIDTH_KEY-1:0] out_data,
    output logic                 err_ovf
);

    localparam int NS = ccm_pkg::N_STREAMS;
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int SW = FW + 1;

    ccm_pkg::req_state_e state_q;

    logic                 ctr_ready_q;
    logic                 ctr_idx_q;
    logic                 last_grant_q;
    logic [FW-1:0]        outst_q [NS];
    logic [FW-1:0]        outst_d [NS];
    logic [FW-1:0]        fill    [NS];
    logic [WIDTH_KEY-1:0] head    [NS];
    logic [NS-1:0]        elig;
    logic [NS-1:0]        inc;
    logic [NS-1:0]        push;
    logic [NS-1:0]        pop;
    logic                 grant;
    logic                 grant_idx;
    logic                 ret_ok;
    logic                 err_q;
    logic                 out_valid_q;
    logic                 out_idx_q;
    logic [WIDTH_KEY-1:0] out_data_q;

    for (genvar s = 0; s < NS; s++) begin : g_fifo
        ccm_ks_fifo #(
            .W     (WIDTH_KEY),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .kill        (kill),
            .push_i      (push[s]),
            .push_data_i (ctr_data),
            .pop_i       (pop[s]),
            .head_o      (head[s]),
            .fill_o      (fill[s])
        );
    end

    // A stream may ask only while buffered plus in-flight fits.
    always_comb begin
        elig = '0;
        for (int s = 0; s < NS; s++) begin
            elig[s] = (SW'(fill[s]) + SW'(outst_q[s])) < SW'(DEPTH);
        end
    end

    always_comb begin
        grant     = 1'b0;
        grant_idx = 1'b0;
        if (state_q == ccm_pkg::ST_ARB && run) begin
            unique case (elig)
                2'b11: begin
                    grant     = 1'b1;
                    grant_idx = ~last_grant_q;
                end
                2'b01: begin
                    grant     = 1'b1;
                    grant_idx = 1'b0;
                end
                2'b10: begin
                    grant     = 1'b1;
                    grant_idx = 1'b1;
                end
                default: begin
                    grant     = 1'b0;
                    grant_idx = 1'b0;
                end
            endcase
        end
    end

    assign ret_ok    = ctr_en && (outst_q[ctr_ret_idx] != '0);
    assign in_accept = in_valid && (fill[in_stream_idx] != '0);

    assign inc  = {grant & grant_idx, grant & ~grant_idx};
    assign push = {ret_ok & ctr_ret_idx, ret_ok & ~ctr_ret_idx};
    assign pop  = {in_accept & in_stream_idx,
                   in_accept & ~in_stream_idx};

    always_comb begin
        outst_d = outst_q;
        for (int s = 0; s < NS; s++) begin
            unique case ({inc[s], push[s]})
                2'b10:   outst_d[s] = outst_q[s] + FW'(1);
                2'b01:   outst_d[s] = outst_q[s] - FW'(1);
                default: outst_d[s] = outst_q[s];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q      <= ccm_pkg::ST_IDLE;
            ctr_ready_q  <= 1'b0;
            ctr_idx_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            ctr_ready_q <= 1'b0;
            ctr_idx_q   <= 1'b0;
            unique case (state_q)
                ccm_pkg::ST_IDLE: begin
                    if (run) begin
                        state_q <= ccm_pkg::ST_ARB;
                    end
                end
                ccm_pkg::ST_ARB: begin
                    if (!run) begin
                        state_q <= ccm_pkg::ST_IDLE;
                    end else if (grant) begin
                        ctr_ready_q  <= 1'b1;
                        ctr_idx_q    <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= ccm_pkg::ST_HOLD;
                    end
                end
                ccm_pkg::ST_HOLD: begin
                    state_q <= ccm_pkg::ST_ARB;
                end
                default: begin
                    state_q <= ccm_pkg::ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            for (int s = 0; s < NS; s++) begin
                outst_q[s] <= '0;
            end
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            outst_q     <= outst_d;
            out_valid_q <= in_accept;
            if (ctr_en && !ret_ok) begin
                err_q <= 1'b1;
            end
            if (in_accept) begin
                out_idx_q  <= in_stream_idx;
                out_data_q <= in_data ^ head[in_stream_idx];
            end
        end
    end

    assign ctr_ready      = ctr_ready_q;
    assign ctr_stream_idx = ctr_idx_q;
    assign out_valid      = out_valid_q;
    assign out_stream_idx = out_idx_q;
    assign out_data       = out_data_q;
    assign err_ovf        = err_q;

endmodule
